// File: rtl/module_fsm_rx_if.sv
// module_fsm_rx_if: receiver-core and register-bank handshake bundle for module_fsm_rx.
interface module_fsm_rx_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    logic                   rx_rdy_i;
    logic [DATA_W-1:0]      rx_data_i;
    logic                   control_rx_i;
    logic                   clr_ovr_i;
    logic [DATA_W-1:0]      data_o;
    logic                   wr_o;
    logic                   new_rx_o;
    logic                   overrun_o;
    logic [$clog2(DEPTH):0] count_o;
    logic                   timeout_o;

    modport slave (
        input  rx_rdy_i, rx_data_i, control_rx_i, clr_ovr_i,
        output data_o, wr_o, new_rx_o, overrun_o, count_o, timeout_o
    );

    modport master (
        output rx_rdy_i, rx_data_i, control_rx_i, clr_ovr_i,
        input  data_o, wr_o, new_rx_o, overrun_o, count_o, timeout_o
    );
endinterface

// File: rtl/module_fsm_rx.sv
// module_fsm_rx: UART receive FIFO plus byte-presentation FSM toward the register bank.
// Optional RX_WATCHDOG_EN adds a WAIT-state timeout that forces CLEAR and sets timeout_o.
module module_fsm_rx #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input logic               clk_i,
    input logic               reset_i,
    module_fsm_rx_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, WAIT, CLEAR} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [DATA_W-1:0] data_r;
    logic              overrun_r;
    logic              full, empty, pop, push, wd_hit;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign pop   = state == LOAD;
    assign push  = bus.rx_rdy_i && (!full || pop);

    always_ff @(posedge clk_i)
        if (push) mem[wr_ptr] <= bus.rx_data_i;

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_r    <= '0;
            overrun_r <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                data_r <= mem[rd_ptr];
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            // a drop in the same cycle as a clear keeps the flag set
            if (bus.rx_rdy_i && full && !pop) overrun_r <= 1'b1;
            else if (bus.clr_ovr_i) overrun_r <= 1'b0;
        end

`ifdef RX_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wd_cnt;
    logic          timeout_r;
    assign wd_hit = state == WAIT && !bus.control_rx_i && wd_cnt == WW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            wd_cnt    <= '0;
            timeout_r <= 1'b0;
        end else begin
            wd_cnt <= state == WAIT ? wd_cnt + 1'b1 : '0;
            if (wd_hit) timeout_r <= 1'b1;
        end
    assign bus.timeout_o = timeout_r;
`else
    assign wd_hit        = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = IDLE;
        unique case (state)
            IDLE:    state_nx = empty ? IDLE : LOAD;
            LOAD:    state_nx = WRITE;
            WRITE:   state_nx = WAIT;
            WAIT:    state_nx = (bus.control_rx_i || wd_hit) ? CLEAR : WAIT;
            CLEAR:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.wr_o     = state == WRITE;
        bus.new_rx_o = state == WRITE || state == WAIT;
    end

    assign bus.data_o    = data_r;
    assign bus.count_o   = count;
    assign bus.overrun_o = overrun_r;
endmodule

// File: tb/tb_module_fsm_rx.sv
// tb_module_fsm_rx: table-driven cycle vectors plus hand sequences for drain, reset and watchdog.
module tb_module_fsm_rx;
    localparam int DW = 8, DEPTH = 4, TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    module_fsm_rx_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();
    module_fsm_rx #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .reset_i(rst), .bus(bus)
    );

    typedef struct {
        logic rdy; logic [7:0] din; logic ctl; logic clr;
        logic wr; logic nw; logic [7:0] dat; logic [2:0] cnt; logic ovr;
    } vec_t;

    vec_t       vq[$];
    int         passed = 0, total = 0;
    logic [7:0] drain_d [4] = '{8'hA2, 8'hA3, 8'hA4, 8'hEE};

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    task automatic add(logic rdy, logic [7:0] din, logic ctl, logic clr,
                       logic wr, logic nw, logic [7:0] dat, logic [2:0] cnt, logic ovr);
        vq.push_back('{rdy, din, ctl, clr, wr, nw, dat, cnt, ovr});
    endtask

    task automatic drive(logic rdy, logic [7:0] din, logic ctl, logic clr);
        bus.rx_rdy_i = rdy; bus.rx_data_i = din; bus.control_rx_i = ctl; bus.clr_ovr_i = clr;
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    task automatic wait_wr(string n);
        bit ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.wr_o) begin ok = 1; break; end
        end
        chk({n, " wr seen"}, 32'(ok), 1);
    endtask

    task automatic chk_all_zero(string n);
        chk({n, " wr"}, 32'(bus.wr_o), 0);
        chk({n, " new"}, 32'(bus.new_rx_o), 0);
        chk({n, " data"}, 32'(bus.data_o), 0);
        chk({n, " count"}, 32'(bus.count_o), 0);
        chk({n, " ovr"}, 32'(bus.overrun_o), 0);
        chk({n, " timeout"}, 32'(bus.timeout_o), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin
        int hi, wrs;
        drive(0, 0, 0, 0);
        #2;
        chk_all_zero("reset");
        next_cyc();
        rst = 1'b0;

        // single byte, host acknowledges late
        add(1, 8'h5A, 0, 0, 0, 0, 8'h00, 0, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 1, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 1, 0);
        add(0, 0, 0, 0, 1, 1, 8'h5A, 0, 0);
        repeat (6) add(0, 0, 0, 0, 0, 1, 8'h5A, 0, 0);
        add(0, 0, 1, 0, 0, 1, 8'h5A, 0, 0);
        add(0, 0, 0, 0, 0, 0, 8'h5A, 0, 0);
        add(0, 0, 0, 0, 0, 0, 8'h5A, 0, 0);
        // ordering with control held high: strobes 5 cycles apart
        add(1, 8'h11, 1, 0, 0, 0, 8'h5A, 0, 0);
        add(1, 8'h22, 1, 0, 0, 0, 8'h5A, 1, 0);
        add(1, 8'h33, 1, 0, 0, 0, 8'h5A, 2, 0);
        add(0, 0, 1, 0, 1, 1, 8'h11, 2, 0);
        add(0, 0, 1, 0, 0, 1, 8'h11, 2, 0);
        repeat (3) add(0, 0, 1, 0, 0, 0, 8'h11, 2, 0);
        add(0, 0, 1, 0, 1, 1, 8'h22, 1, 0);
        add(0, 0, 1, 0, 0, 1, 8'h22, 1, 0);
        repeat (3) add(0, 0, 1, 0, 0, 0, 8'h22, 1, 0);
        add(0, 0, 1, 0, 1, 1, 8'h33, 0, 0);
        add(0, 0, 1, 0, 0, 1, 8'h33, 0, 0);
        repeat (2) add(0, 0, 1, 0, 0, 0, 8'h33, 0, 0);
        // overflow: A5 is dropped
        add(1, 8'hA0, 0, 0, 0, 0, 8'h33, 0, 0);
        add(1, 8'hA1, 0, 0, 0, 0, 8'h33, 1, 0);
        add(1, 8'hA2, 0, 0, 0, 0, 8'h33, 2, 0);
        add(1, 8'hA3, 0, 0, 1, 1, 8'hA0, 2, 0);
        add(1, 8'hA4, 0, 0, 0, 1, 8'hA0, 3, 0);
        add(1, 8'hA5, 0, 0, 0, 1, 8'hA0, 4, 0);
        add(0, 0, 0, 0, 0, 1, 8'hA0, 4, 1);
        add(0, 0, 0, 1, 0, 1, 8'hA0, 4, 1);
        add(0, 0, 0, 0, 0, 1, 8'hA0, 4, 0);
        // full FIFO: push coincides with LOAD pop
        add(0, 0, 1, 0, 0, 1, 8'hA0, 4, 0);
        add(0, 0, 0, 0, 0, 0, 8'hA0, 4, 0);
        add(0, 0, 0, 0, 0, 0, 8'hA0, 4, 0);
        add(1, 8'hEE, 0, 0, 0, 0, 8'hA0, 4, 0);
        add(0, 0, 0, 0, 1, 1, 8'hA1, 4, 0);
        // drop and clear in the same cycle: set wins
        add(1, 8'hFF, 0, 1, 0, 1, 8'hA1, 4, 0);
        add(0, 0, 0, 1, 0, 1, 8'hA1, 4, 1);
        add(0, 0, 0, 0, 0, 1, 8'hA1, 4, 0);

        foreach (vq[i]) begin
            drive(vq[i].rdy, vq[i].din, vq[i].ctl, vq[i].clr);
            @(negedge clk);
            chk($sformatf("row%0d wr", i), 32'(bus.wr_o), 32'(vq[i].wr));
            chk($sformatf("row%0d new", i), 32'(bus.new_rx_o), 32'(vq[i].nw));
            chk($sformatf("row%0d data", i), 32'(bus.data_o), 32'(vq[i].dat));
            chk($sformatf("row%0d count", i), 32'(bus.count_o), 32'(vq[i].cnt));
            chk($sformatf("row%0d ovr", i), 32'(bus.overrun_o), 32'(vq[i].ovr));
            next_cyc();
        end

        drive(0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            wait_wr($sformatf("drain%0d", k));
            chk($sformatf("drain%0d data", k), 32'(bus.data_o), 32'(drain_d[k]));
        end
        next_cyc();
        repeat (6) next_cyc();
        chk("drained count", 32'(bus.count_o), 0);
        chk("drained ovr", 32'(bus.overrun_o), 0);

        // reset mid-stream: one byte waiting, two buffered
        drive(1, 8'h01, 0, 0); next_cyc();
        drive(1, 8'h02, 0, 0); next_cyc();
        drive(1, 8'h03, 0, 0); next_cyc();
        drive(0, 0, 0, 0);
        repeat (8) next_cyc();
        @(negedge clk);
        chk("pre-reset new", 32'(bus.new_rx_o), 1);
        chk("pre-reset count", 32'(bus.count_o), 2);
        chk("pre-reset data", 32'(bus.data_o), 8'h01);
        #1 rst = 1'b1;
        #1 chk_all_zero("async reset");
        next_cyc();
        rst = 1'b0;
        wrs = 0;
        repeat (10) begin
            @(negedge clk);
            wrs += int'(bus.wr_o);
        end
        chk("post-reset wr pulses", 32'(wrs), 0);
        chk("post-reset count", 32'(bus.count_o), 0);
        next_cyc();

        // watchdog / indefinite hold
        drive(1, 8'h77, 0, 0); next_cyc();
        drive(0, 0, 0, 0);
        wait_wr("wd byte");
        chk("wd data", 32'(bus.data_o), 8'h77);
        hi = 1;
`ifdef RX_WATCHDOG_EN
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!bus.new_rx_o) break;
            hi++;
        end
        chk("wd new high cycles", 32'(hi), 32'(TO + 1));
        chk("wd timeout", 32'(bus.timeout_o), 1);
        chk("wd new after", 32'(bus.new_rx_o), 0);
`else
        repeat (1000) begin
            @(negedge clk);
            hi += int'(bus.new_rx_o);
        end
        chk("hold new high cycles", 32'(hi), 1001);
        chk("hold timeout", 32'(bus.timeout_o), 0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
